// File: rtl/control_sequencer.sv
// Multi-cycle LEGv8-subset control unit: accepts one instruction per handshake and
// steps DECODE/EXEC or DECODE/ADDR/MEM_* while driving the datapath control word.
module control_sequencer #(
  parameter int CW_WIDTH = 27,
  parameter int K_WIDTH  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          status,
  output logic [CW_WIDTH-1:0] control_word,
  output logic [K_WIDTH-1:0]  k,
  output logic [3:0]          flags,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    ADDR,
    MEM_RD,
    MEM_WR
  } state_t;

  typedef enum logic [2:0] {
    KIND_ILLEGAL,
    KIND_RTYPE,
    KIND_ITYPE,
    KIND_SHIFT,
    KIND_LDUR,
    KIND_STUR
  } kind_t;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  state_t      state, next_state;
  kind_t       kind;
  logic [31:0] ir;
  logic [4:0]  dec_fs;
  logic        dec_cin;

  logic [4:0]  rd, rn, rm;
  logic [5:0]  shamt;
  logic [11:0] imm12;
  logic [8:0]  dt;

  logic [4:0]  fs, aa, ab, da;
  logic        cin, rf_w, ram_write, en_alu, en_ram, b_sel, status_load;

  assign rd    = ir[4:0];
  assign rn    = ir[9:5];
  assign rm    = ir[20:16];
  assign shamt = ir[15:10];
  assign imm12 = ir[21:10];
  assign dt    = ir[20:12];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= '0;
    end else if (state == IDLE && instr_valid) begin
      ir <= instr;
    end
  end

  // Flags only follow the ALU on the cycle an arithmetic result is committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else if (state == EXEC) begin
      flags <= status;
    end
  end

  // Immediate forms use a 10-bit opcode, so they are matched before the 11-bit table.
  always_comb begin
    kind    = KIND_ILLEGAL;
    dec_fs  = FS_AND;
    dec_cin = 1'b0;
    if (ir[31:22] == OPC_ADDI) begin
      kind   = KIND_ITYPE;
      dec_fs = FS_ADD;
    end else if (ir[31:22] == OPC_SUBI) begin
      kind    = KIND_ITYPE;
      dec_fs  = FS_SUB;
      dec_cin = 1'b1;
    end else begin
      case (ir[31:21])
        OPC_ADD: begin
          kind   = KIND_RTYPE;
          dec_fs = FS_ADD;
        end
        OPC_SUB: begin
          kind    = KIND_RTYPE;
          dec_fs  = FS_SUB;
          dec_cin = 1'b1;
        end
        OPC_AND: begin
          kind   = KIND_RTYPE;
          dec_fs = FS_AND;
        end
        OPC_ORR: begin
          kind   = KIND_RTYPE;
          dec_fs = FS_ORR;
        end
        OPC_EOR: begin
          kind   = KIND_RTYPE;
          dec_fs = FS_EOR;
        end
        OPC_LSL: begin
          kind   = KIND_SHIFT;
          dec_fs = FS_LSL;
        end
        OPC_LSR: begin
          kind   = KIND_SHIFT;
          dec_fs = FS_LSR;
        end
        OPC_LDUR: begin
          kind   = KIND_LDUR;
          dec_fs = FS_ADD;
        end
        OPC_STUR: begin
          kind   = KIND_STUR;
          dec_fs = FS_ADD;
        end
        default: kind = KIND_ILLEGAL;
      endcase
    end
  end

  // All outputs are decoded from the current state so reset clears them instantly.
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    k           = '0;
    fs          = '0;
    cin         = 1'b0;
    aa          = '0;
    ab          = '0;
    da          = '0;
    rf_w        = 1'b0;
    ram_write   = 1'b0;
    en_alu      = 1'b0;
    en_ram      = 1'b0;
    b_sel       = 1'b0;
    status_load = 1'b0;

    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          next_state = DECODE;
        end
      end

      DECODE: begin
        case (kind)
          KIND_RTYPE, KIND_ITYPE, KIND_SHIFT: next_state = EXEC;
          KIND_LDUR, KIND_STUR:               next_state = ADDR;
          default: begin
            illegal    = 1'b1;
            next_state = IDLE;
          end
        endcase
      end

      EXEC: begin
        fs          = dec_fs;
        cin         = dec_cin;
        aa          = rn;
        da          = rd;
        rf_w        = 1'b1;
        en_alu      = 1'b1;
        status_load = 1'b1;
        done        = 1'b1;
        case (kind)
          KIND_ITYPE: begin
            b_sel = 1'b1;
            k     = {{(K_WIDTH-12){1'b0}}, imm12};
          end
          KIND_SHIFT: begin
            b_sel = 1'b1;
            k     = {{(K_WIDTH-6){1'b0}}, shamt};
          end
          default: ab = rm;
        endcase
        next_state = IDLE;
      end

      ADDR, MEM_RD, MEM_WR: begin
        fs    = FS_ADD;
        aa    = rn;
        b_sel = 1'b1;
        k     = {{(K_WIDTH-9){dt[8]}}, dt};
        if (state == ADDR) begin
          next_state = (kind == KIND_LDUR) ? MEM_RD : MEM_WR;
        end else if (state == MEM_RD) begin
          en_ram     = 1'b1;
          da         = rd;
          rf_w       = 1'b1;
          done       = 1'b1;
          next_state = IDLE;
        end else begin
          ab         = rd;
          ram_write  = 1'b1;
          done       = 1'b1;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  assign control_word = {fs, cin, aa, ab, da, rf_w, ram_write, en_alu, en_ram, b_sel, status_load};

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle outputs are queued
// when an instruction is issued and compared on each following falling edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  status;
  logic [26:0] control_word;
  logic [63:0] k;
  logic [3:0]  flags;
  logic        done;
  logic        illegal;

  typedef struct {
    logic [26:0] cw;
    logic [63:0] k;
    logic        done;
    logic        illegal;
    logic        ready;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_flags;

  control_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .status       (status),
    .control_word (control_word),
    .k            (k),
    .flags        (flags),
    .done         (done),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] mk_cw(input logic [4:0] fs, input logic cin,
                                        input logic [4:0] aa, input logic [4:0] ab,
                                        input logic [4:0] da, input logic rfw,
                                        input logic ramw, input logic enalu,
                                        input logic enram, input logic bsel,
                                        input logic sl);
    return {fs, cin, aa, ab, da, rfw, ramw, enalu, enram, bsel, sl};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [26:0] cw, input logic [63:0] kv, input logic dn,
                      input logic ill, input logic rdy, input logic [3:0] fl);
    exp_t e;
    e.cw = cw; e.k = kv; e.done = dn; e.illegal = ill; e.ready = rdy; e.flags = fl;
    sb.push_back(e);
  endtask

  task automatic checkNow(input string tag, input exp_t e);
    checkOutput({tag, ".cw"},      64'(control_word), 64'(e.cw));
    checkOutput({tag, ".k"},       k,                 e.k);
    checkOutput({tag, ".done"},    64'(done),         64'(e.done));
    checkOutput({tag, ".illegal"}, 64'(illegal),      64'(e.illegal));
    checkOutput({tag, ".ready"},   64'(instr_ready),  64'(e.ready));
    checkOutput({tag, ".flags"},   64'(flags),        64'(e.flags));
  endtask

  // Called at a falling edge with the DUT idle; expected cycles are already queued.
  task automatic applyStimulus(input string tag, input logic [31:0] word,
                               input logic [3:0] st, input bit hold,
                               input logic [31:0] next_word);
    int cyc = 0;
    exp_t e;
    instr       = word;
    instr_valid = 1'b1;
    status      = st;
    @(posedge clk);
    #1;
    instr       = next_word;
    instr_valid = hold;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkNow($sformatf("%s.c%0d", tag, cyc), e);
      cyc++;
    end
  endtask

  task automatic pushIdle();
    push(27'd0, 64'd0, 1'b0, 1'b0, 1'b1, exp_flags);
  endtask

  localparam logic [31:0] I_ADD  = 32'h8B020023;
  localparam logic [31:0] I_SUBI = 32'hD10028A5;
  localparam logic [31:0] I_LDUR = 32'hF85F8047;
  localparam logic [31:0] I_STUR = 32'hF8010089;
  localparam logic [31:0] I_ORR  = {11'b10101010000, 5'd8, 6'd0, 5'd7, 5'd6};

  logic [10:0] ropc [7];
  logic [4:0]  rfs  [9];
  logic        rcin [9];

  initial begin
    exp_t e;
    logic [31:0] w;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  sh;
    logic [11:0] imm;
    logic [3:0]  st;
    int          op;

    ropc = '{11'b10001010000, 11'b10101010000, 11'b11001010000, 11'b10001011000,
             11'b11001011000, 11'b11010011011, 11'b11010011010};
    rfs  = '{5'b00000, 5'b00100, 5'b01100, 5'b01000, 5'b01001, 5'b10000, 5'b10100,
             5'b01000, 5'b01001};
    rcin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset       = 1'b0;
    instr       = 32'd0;
    instr_valid = 1'b0;
    status      = 4'd0;
    exp_flags   = 4'd0;
    repeat (2) @(negedge clk);
    e.cw = 0; e.k = 0; e.done = 0; e.illegal = 0; e.ready = 1; e.flags = 0;
    checkNow("reset", e);
    reset = 1'b1;
    @(negedge clk);

    // ADD X3,X1,X2
    push(27'd0, 64'd0, 1'b0, 1'b0, 1'b0, exp_flags);
    push(mk_cw(5'b01000, 0, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 1), 64'd0, 1, 0, 0, exp_flags);
    exp_flags = 4'b0101;
    pushIdle();
    applyStimulus("add", I_ADD, 4'b0101, 1'b0, 32'd0);

    // SUBI X5,X5,#10
    push(27'd0, 64'd0, 1'b0, 1'b0, 1'b0, exp_flags);
    push(mk_cw(5'b01001, 1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 1, 1), 64'd10, 1, 0, 0, exp_flags);
    exp_flags = 4'b1000;
    pushIdle();
    applyStimulus("subi", I_SUBI, 4'b1000, 1'b0, 32'd0);

    // LDUR X7,[X2,#-8] with STUR held on instr_valid while busy
    push(27'd0, 64'd0, 1'b0, 1'b0, 1'b0, exp_flags);
    push(mk_cw(5'b01000, 0, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, exp_flags);
    push(mk_cw(5'b01000, 0, 5'd2, 5'd0, 5'd7, 1, 0, 0, 1, 1, 0), 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, exp_flags);
    pushIdle();
    applyStimulus("ldur", I_LDUR, 4'b0011, 1'b1, I_STUR);

    // STUR X9,[X4,#16]
    push(27'd0, 64'd0, 1'b0, 1'b0, 1'b0, exp_flags);
    push(mk_cw(5'b01000, 0, 5'd4, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), 64'd16, 0, 0, 0, exp_flags);
    push(mk_cw(5'b01000, 0, 5'd4, 5'd9, 5'd0, 0, 1, 0, 0, 1, 0), 64'd16, 1, 0, 0, exp_flags);
    pushIdle();
    applyStimulus("stur", I_STUR, 4'b0110, 1'b0, 32'd0);

    // Reset pulled low in the middle of an ADD's EXEC cycle
    instr       = I_ADD;
    instr_valid = 1'b1;
    status      = 4'b1111;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid.decode_cw", 64'(control_word), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_mid.exec_cw", 64'(control_word),
                64'(mk_cw(5'b01000, 0, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, 0, 1)));
    #1;
    reset = 1'b0;
    #1;
    exp_flags = 4'd0;
    e.cw = 0; e.k = 0; e.done = 0; e.illegal = 0; e.ready = 1; e.flags = 0;
    checkNow("rst_mid.async", e);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkNow("rst_mid.after", e);

    // Illegal opcode with ORR held valid during the busy cycle
    push(27'd0, 64'd0, 1'b0, 1'b1, 1'b0, exp_flags);
    pushIdle();
    applyStimulus("illegal", 32'd0, 4'b1010, 1'b1, I_ORR);

    // ORR X6,X7,X8 accepted at the first idle cycle
    push(27'd0, 64'd0, 1'b0, 1'b0, 1'b0, exp_flags);
    push(mk_cw(5'b00100, 0, 5'd7, 5'd8, 5'd6, 1, 0, 1, 0, 0, 1), 64'd0, 1, 0, 0, exp_flags);
    exp_flags = 4'b1001;
    pushIdle();
    applyStimulus("orr", I_ORR, 4'b1001, 1'b0, 32'd0);

    // Random ALU operations over all R, shift and immediate forms
    for (int i = 0; i < 12; i++) begin
      op  = $urandom_range(0, 8);
      rd  = 5'($urandom_range(0, 31));
      rn  = 5'($urandom_range(0, 31));
      rm  = 5'($urandom_range(0, 31));
      sh  = 6'($urandom_range(0, 63));
      imm = 12'($urandom_range(0, 4095));
      st  = 4'($urandom_range(0, 15));
      push(27'd0, 64'd0, 1'b0, 1'b0, 1'b0, exp_flags);
      if (op <= 4) begin
        w = {ropc[op], rm, sh, rn, rd};
        push(mk_cw(rfs[op], rcin[op], rn, rm, rd, 1, 0, 1, 0, 0, 1), 64'd0, 1, 0, 0, exp_flags);
      end else if (op <= 6) begin
        w = {ropc[op], rm, sh, rn, rd};
        push(mk_cw(rfs[op], rcin[op], rn, 5'd0, rd, 1, 0, 1, 0, 1, 1), {58'd0, sh}, 1, 0, 0, exp_flags);
      end else begin
        w = {(op == 7) ? 10'b1001000100 : 10'b1101000100, imm, rn, rd};
        push(mk_cw(rfs[op], rcin[op], rn, 5'd0, rd, 1, 0, 1, 0, 1, 1), {52'd0, imm}, 1, 0, 0, exp_flags);
      end
      exp_flags = st;
      pushIdle();
      applyStimulus($sformatf("rnd%0d_op%0d", i, op), w, st, 1'b0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
